gcd_unit: RTL and testbench
===========================

# gcd_unit

Parametrised iterative greatest-common-divisor engine and the successor to the fixed 16-bit GCD block. It is generalised to any operand width, and operands arrive as a parallel pair. Computation uses Stein's binary algorithm (shift/subtract only, no divider). Valid/ready handshakes on both input and output let it sit between streaming producer and consumer stages.

## Interface
- WIDTH, 16, operand and result width in bits (≥ 2)
- CW, $clog2(2*WIDTH+2), width of the optional step counter (derived; do not override)

- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  unit can accept a pair
- in_a  input  WIDTH  operand A (unsigned)
- in_b  input  WIDTH  operand B (unsigned)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_gcd  output  WIDTH  gcd(A,B)
- out_steps  output  CW  CALC cycles used (present only with GCD_STEP_CNT_EN)

## Operation
- State machine: IDLE, CALC, DONE. Internal registers are a, b (WIDTH) and k (shift count, $clog2(WIDTH)+1 bits).
- IDLE:
  - in_ready = 1.
  - On in_valid: latch a = in_a, b = in_b, k = 0.
  - If in_a == 0 or in_b == 0: load out_gcd = in_a | in_b and go to DONE. This gives gcd(0,x) = x and gcd(0,0) = 0.
  - Otherwise go to CALC.
- CALC: one step per cycle, checked in this priority order:
  - a == b: out_gcd = a << k, go to DONE.
  - a and b both even: a >>= 1, b >>= 1, k++.
  - a even: a >>= 1.
  - b even: b >>= 1.
  - Both odd and a > b: a = (a−b) >> 1. Otherwise: b = (b−a) >> 1.
- DONE: out_valid = 1 and out_gcd is held stable. On out_valid && out_ready, go to IDLE.
- Arithmetic is unsigned. The subtraction always yields a non-negative even value, so there is no overflow. a << k never exceeds min(in_a, in_b).
- in_ready = (state == IDLE) only. No new pair is accepted while a result is in flight or pending.

## Timing
- Reset (rst == 0 at a clock edge):
  - state = IDLE, out_valid = 0, out_gcd = 0, a/b/k = 0, out_steps = 0.
  - in_ready reads 1 from the first edge after reset.
- Reset mid-CALC or mid-DONE aborts the operation with no output. The pending result is discarded.
- Latency for a zero operand: out_valid is high in the cycle following the accepting edge. out_steps = 0.
- Latency otherwise: N = number of CALC cycles, including the final a == b cycle. out_valid rises on the Nth edge after the accepting edge.
- N ≤ 2*WIDTH + 1 for all inputs.
- Backpressure: while out_ready = 0, out_valid, out_gcd and out_steps hold. in_valid is ignored outside IDLE.
- Same-cycle output handshake and new input: the DONE→IDLE edge consumes the result. The earliest a new pair can be accepted is the next edge, so there is one bubble cycle per operation.

## Configuration
- GCD_STEP_CNT_EN:
  - When defined, out_steps exists. It is a CW-bit counter cleared on accept, incremented on every CALC cycle, and frozen in DONE.
  - When undefined, the port and counter are removed. All other behaviour is identical.

## Test plan
- Reset held 3 cycles, then released → out_valid = 0, out_gcd = 0, in_ready = 1.
- WIDTH = 16, (12, 18) accepted → out_gcd = 6 on the 4th edge after accept; out_steps = 4.
- (65535, 1) → out_gcd = 1 after 16 CALC cycles; out_steps = 16. (7, 7) → out_gcd = 7 after 1 cycle.
- (0, 25) → 25. (0, 0) → 0. Both assert out_valid one cycle after accept with out_steps = 0.
- (12, 18) with out_ready held low 5 cycles → out_valid/out_gcd = 6 stable throughout. in_ready stays 0 while in_valid is held with (9, 6). (9, 6) is then accepted one cycle after the result handshake and yields 3.
- rst pulsed low during CALC of (65535, 1) → no out_valid. The next pair (8, 12) yields 4.
- Random sweep at WIDTH = 8 and 32, compared against a reference Euclid model → all match. N ≤ 2*WIDTH + 1 on every operation.

Source files
------------

// File: rtl/gcd_unit.sv
// Binary (Stein) GCD engine: result after N CALC cycles (N <= 2*WIDTH+1), output held while out_ready is low.
// Defining GCD_STEP_CNT_EN adds the out_steps port reporting the CALC cycles used.
module gcd_unit #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(2*WIDTH+2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef GCD_STEP_CNT_EN
  output logic [CW-1:0]    out_steps,
`endif
  output logic [WIDTH-1:0] out_gcd
);

  localparam int KW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [KW-1:0]    k;
  logic             zero_in;

  assign zero_in = (in_a == '0) || (in_b == '0);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = zero_in ? DONE : CALC;
      CALC:    if (a == b) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Common factors of two are stripped into k and restored on the final a == b step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a       <= '0;
      b       <= '0;
      k       <= '0;
      out_gcd <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a <= in_a;
            b <= in_b;
            k <= '0;
            if (zero_in) out_gcd <= in_a | in_b;
          end
        end
        CALC: begin
          if (a == b) begin
            out_gcd <= a << k;
          end else if (!a[0] && !b[0]) begin
            a <= a >> 1;
            b <= b >> 1;
            k <= k + 1'b1;
          end else if (!a[0]) begin
            a <= a >> 1;
          end else if (!b[0]) begin
            b <= b >> 1;
          end else if (a > b) begin
            a <= (a - b) >> 1;
          end else begin
            b <= (b - a) >> 1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GCD_STEP_CNT_EN
  logic [CW-1:0] steps;

  always_ff @(posedge clk) begin
    if (!rst) begin
      steps <= '0;
    end else if (state == IDLE && in_valid) begin
      steps <= '0;
    end else if (state == CALC) begin
      steps <= steps + 1'b1;
    end
  end

  assign out_steps = steps;
`endif

endmodule

// File: tb/tb_gcd_unit.sv
// Directed and random checks of gcd_unit at WIDTH 16, 8 and 32.
module tb_gcd_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [15:0] in_a = '0, in_b = '0, out_gcd;
  logic        in_valid_8 = 1'b0, in_ready_8, out_valid_8, out_ready_8 = 1'b0;
  logic [7:0]  in_a_8 = '0, in_b_8 = '0, out_gcd_8;
  logic        in_valid_32 = 1'b0, in_ready_32, out_valid_32, out_ready_32 = 1'b0;
  logic [31:0] in_a_32 = '0, in_b_32 = '0, out_gcd_32;
`ifdef GCD_STEP_CNT_EN
  logic [5:0]  out_steps;
  logic [4:0]  out_steps_8;
  logic [6:0]  out_steps_32;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
`ifdef GCD_STEP_CNT_EN
    .out_steps(out_steps),
`endif
    .out_gcd(out_gcd));

  gcd_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .in_a(in_a_8), .in_b(in_b_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
`ifdef GCD_STEP_CNT_EN
    .out_steps(out_steps_8),
`endif
    .out_gcd(out_gcd_8));

  gcd_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid_32), .in_ready(in_ready_32),
    .in_a(in_a_32), .in_b(in_b_32), .out_valid(out_valid_32), .out_ready(out_ready_32),
`ifdef GCD_STEP_CNT_EN
    .out_steps(out_steps_32),
`endif
    .out_gcd(out_gcd_32));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_gcd(input logic [63:0] x, input logic [63:0] y);
    logic [63:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Counts edges after the accepting edge until out_valid is seen (bounded).
  task automatic wait16(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume16();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("consumed", out_valid, 1'b0);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_g, input int exp_n);
    int n;
    @(negedge clk);
    chk("ready", in_ready, 1'b1);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait16(n);
    chk("latency", n, exp_n);
    chk("gcd", out_gcd, exp_g);
`ifdef GCD_STEP_CNT_EN
    chk("steps", out_steps, exp_n);
`endif
    consume16();
  endtask

  task automatic sweep8(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      logic [7:0] a, b;
      int n;
      a = 8'($urandom_range(255));
      b = (i % 6 == 0) ? a : 8'($urandom_range(255));
      if (i % 9 == 4) a = '0;
      @(negedge clk);
      in_a_8 = a; in_b_8 = b; in_valid_8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid_8 = 1'b0;
      n = 0;
      while (!out_valid_8 && n < 30) begin
        @(negedge clk);
        n++;
      end
      chk("w8_gcd", out_gcd_8, ref_gcd(64'(a), 64'(b)));
      chk("w8_bound", 64'(n <= 17), 64'd1);
`ifdef GCD_STEP_CNT_EN
      chk("w8_steps", out_steps_8, n);
`endif
      out_ready_8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready_8 = 1'b0;
    end
  endtask

  task automatic sweep32(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      logic [31:0] a, b;
      int n;
      a = $urandom;
      b = (i % 7 == 0) ? (a << 3) : $urandom;
      if (i % 11 == 5) b = '0;
      @(negedge clk);
      in_a_32 = a; in_b_32 = b; in_valid_32 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid_32 = 1'b0;
      n = 0;
      while (!out_valid_32 && n < 80) begin
        @(negedge clk);
        n++;
      end
      chk("w32_gcd", out_gcd_32, ref_gcd(64'(a), 64'(b)));
      chk("w32_bound", 64'(n <= 65), 64'd1);
`ifdef GCD_STEP_CNT_EN
      chk("w32_steps", out_steps_32, n);
`endif
      out_ready_32 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready_32 = 1'b0;
    end
  endtask

  initial begin
    int n;
    int seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_gcd", out_gcd, 16'd0);
    chk("rst_ready", in_ready, 1'b1);
`ifdef GCD_STEP_CNT_EN
    chk("rst_steps", out_steps, 0);
`endif

    run16(16'd12, 16'd18, 16'd6, 4);
    run16(16'd65535, 16'd1, 16'd1, 16);
    run16(16'd7, 16'd7, 16'd7, 1);
    run16(16'd0, 16'd25, 16'd25, 0);
    run16(16'd0, 16'd0, 16'd0, 0);

    // Backpressure: result held while a new pair waits on in_valid.
    @(negedge clk);
    in_a = 16'd12; in_b = 16'd18; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait16(n);
    chk("bp_latency", n, 4);
    in_a = 16'd9; in_b = 16'd6; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_gcd", out_gcd, 16'd6);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bubble_valid", out_valid, 1'b0);
    chk("bubble_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait16(n);
    chk("next_latency", n, 3);
    chk("next_gcd", out_gcd, 16'd3);
    consume16();

    // Reset during CALC discards the operation.
    @(negedge clk);
    in_a = 16'd65535; in_b = 16'd1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_valid", seen, 0);
    chk("abort_ready", in_ready, 1'b1);
    run16(16'd8, 16'd12, 16'd4, 5);

    sweep8(40);
    sweep32(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
